// File: rtl/demand_priority_encoder.sv
// rtl/demand_priority_encoder.sv - detector filtering, per-approach queue counters and demand-based priority select
module demand_priority_encoder #(
    parameter int DEBOUNCE  = 8,
    parameter int CNT_W     = 6,
    parameter int SERVE_INT = 16,
    parameter int MIN_HOLD  = 64,
    parameter int HYST      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] det,
    input  logic [3:0] serve,
    output logic [1:0] prio,
    output logic       demand_any,
    output logic       overflow
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int DR_W   = $clog2(SERVE_INT + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [3:0]        filt;
    logic [3:0]        filt_d;
    logic [DB_W-1:0]   db_cnt [4];
    logic [DR_W-1:0]   drain  [4];
    logic [CNT_W-1:0]  cnt    [4];
    logic [HOLD_W-1:0] hold;

    logic [3:0]        arrival;
    logic [3:0]        inc_ok;
    logic [3:0]        dec_ok;
    logic [1:0]        best;
    logic [CNT_W-1:0]  cnt_best;
    logic [CNT_W-1:0]  cnt_cur;
    logic              any_nz;
    logic              switch_ok;

    always_comb begin
        arrival = filt & ~filt_d;
        inc_ok  = '0;
        dec_ok  = '0;
        any_nz  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // Saturation: an arrival at max and a drain at zero are both dropped.
            inc_ok[i] = arrival[i] && (cnt[i] != CNT_MAX);
            dec_ok[i] = serve[i] && (drain[i] == DR_W'(SERVE_INT - 1)) && (cnt[i] != '0);
            any_nz    = any_nz || (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            filt     <= '0;
            filt_d   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
                drain[i]  <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            sync1  <= det;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    db_cnt[i] <= '0;
                    filt[i]   <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end

                if (!serve[i] || (drain[i] == DR_W'(SERVE_INT - 1))) begin
                    drain[i] <= '0;
                end else begin
                    drain[i] <= drain[i] + 1'b1;
                end

                if (inc_ok[i] && !dec_ok[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!inc_ok[i] && dec_ok[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end

                if (arrival[i] && (cnt[i] == CNT_MAX)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Ties keep the lowest index because only a strictly larger count moves best.
    always_comb begin
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt[i] > cnt[best]) begin
                best = 2'(i);
            end
        end
        cnt_best  = cnt[best];
        cnt_cur   = cnt[prio];
        switch_ok = (hold == '0) && (best != prio) && (cnt_best != '0) &&
                    (({1'b0, cnt_best} >= ({1'b0, cnt_cur} + (CNT_W + 1)'(HYST))) ||
                     (cnt_cur == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio       <= 2'd0;
            hold       <= '0;
            demand_any <= 1'b0;
        end else begin
            demand_any <= any_nz;
            if (switch_ok) begin
                prio <= best;
                hold <= HOLD_W'(MIN_HOLD - 1);
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

endmodule
